// File: rtl/incdec_count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : incdec_count_monitor
// Description : Watermark/wrap monitor for an up/down counter: hysteretic
//               LOW/MID/HIGH flags, entry pulses, sticky ovf/unf.
// Revision    : 1.0 - initial release
// ============================================================================
module incdec_count_monitor #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LO_MARK = 4,
  parameter int unsigned HI_MARK = 28,
  parameter int unsigned HYST    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] count,
  input  logic             clr_sticky,
  output logic             lo_flag,
  output logic             hi_flag,
  output logic             zero_flag,
  output logic             lo_enter,
  output logic             hi_enter,
  output logic             ovf,
  output logic             unf
);

  localparam logic [1:0] S_LOW  = 2'd0;
  localparam logic [1:0] S_MID  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;

  // Thresholds carried at WIDTH+1 bits so mark +/- hysteresis cannot wrap.
  localparam logic [WIDTH:0] C_LO    = (WIDTH+1)'(LO_MARK);
  localparam logic [WIDTH:0] C_HI    = (WIDTH+1)'(HI_MARK);
  localparam logic [WIDTH:0] C_HYST  = (WIDTH+1)'(HYST);
  localparam logic [WIDTH:0] C_LO_UP = C_LO + C_HYST;
  localparam logic [WIDTH:0] C_HI_DN = C_HI - C_HYST;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH:0]   count_x;
  logic [WIDTH-1:0] count_q;
  logic             cmd_inc_q;
  logic             cmd_dec_q;
  logic             eff_inc;
  logic             eff_dec;
  logic             ovf_set;
  logic             unf_set;

  assign count_x = {1'b0, count};
  assign eff_inc = enable & ~load &  inc & ~dec;
  assign eff_dec = enable & ~load & ~inc &  dec;
  assign ovf_set = cmd_inc_q & (count < count_q);
  assign unf_set = cmd_dec_q & (count > count_q);

  always_comb begin
    next_state = state;
    if (count_x >= C_HI && state != S_HIGH)
      next_state = S_HIGH;
    else if (count_x < C_LO && state != S_LOW)
      next_state = S_LOW;
    else if (state == S_LOW && count_x >= C_LO_UP)
      next_state = S_MID;
    else if (state == S_HIGH && count_x < C_HI_DN)
      next_state = S_MID;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_LOW;
      lo_enter  <= 1'b0;
      hi_enter  <= 1'b0;
      zero_flag <= 1'b1;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      cmd_inc_q <= 1'b0;
      cmd_dec_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state     <= next_state;
      lo_enter  <= (next_state == S_LOW)  && (state != S_LOW);
      hi_enter  <= (next_state == S_HIGH) && (state != S_HIGH);
      zero_flag <= (count == '0);
      // A wrap detected in the same cycle as a clear still sets the bit.
      ovf       <= ovf_set | (ovf & ~clr_sticky);
      unf       <= unf_set | (unf & ~clr_sticky);
      cmd_inc_q <= eff_inc;
      cmd_dec_q <= eff_dec;
      count_q   <= count;
    end
  end

  assign lo_flag = (state == S_LOW);
  assign hi_flag = (state == S_HIGH);

endmodule
`default_nettype wire

// File: tb/tb_incdec_count_monitor.sv
`default_nettype none
// Bench for incdec_count_monitor: a behavioural up/down counter drives the DUT,
// a rule-level reference model is compared every cycle, plus literal pins.
module tb_incdec_count_monitor;

  localparam int W  = 8;
  localparam int LO = 4;
  localparam int HI = 12;
  localparam int HY = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic         inc = 1'b0;
  logic         dec = 1'b0;
  logic         clr_sticky = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] cnt;
  logic lo_flag, hi_flag, zero_flag, lo_enter, hi_enter, ovf, unf;

  int errors = 0;
  int checks = 0;

  incdec_count_monitor #(.WIDTH(W), .LO_MARK(LO), .HI_MARK(HI), .HYST(HY)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .inc(inc), .dec(dec),
    .count(cnt), .clr_sticky(clr_sticky), .lo_flag(lo_flag), .hi_flag(hi_flag),
    .zero_flag(zero_flag), .lo_enter(lo_enter), .hi_enter(hi_enter),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Monitored counter
  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (enable && inc && !dec) cnt <= cnt + 1'b1;
    else if (enable && dec && !inc) cnt <= cnt - 1'b1;
  end

  typedef struct packed {
    logic lo, hi, le, he, ovf, unf, zero;
  } exp_t;

  localparam exp_t EXP_RESET = '{lo: 1'b1, hi: 1'b0, le: 1'b0, he: 1'b0,
                                 ovf: 1'b0, unf: 1'b0, zero: 1'b1};

  exp_t m;
  int   m_cmd;   // 0 none, 1 inc, 2 dec
  int   m_prev;

  function automatic exp_t next_exp(exp_t cur, int c, int cmd, int prev, logic clr);
    exp_t n;
    n = cur;
    if (c >= HI && !cur.hi) begin n.hi = 1'b1; n.lo = 1'b0; end
    else if (c < LO && !cur.lo) begin n.lo = 1'b1; n.hi = 1'b0; end
    else if (cur.lo && c >= LO + HY) n.lo = 1'b0;
    else if (cur.hi && c < HI - HY) n.hi = 1'b0;
    n.le   = n.lo && !cur.lo;
    n.he   = n.hi && !cur.hi;
    n.ovf  = (cmd == 1 && c < prev) || (cur.ovf && !clr);
    n.unf  = (cmd == 2 && c > prev) || (cur.unf && !clr);
    n.zero = (c == 0);
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m      <= EXP_RESET;
      m_cmd  <= 0;
      m_prev <= 0;
    end else begin
      m      <= next_exp(m, int'(cnt), m_cmd, m_prev, clr_sticky);
      m_cmd  <= (enable && !load && inc && !dec) ? 1 :
                (enable && !load && dec && !inc) ? 2 : 0;
      m_prev <= int'(cnt);
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_lo_flag",   lo_flag,   m.lo);
      chk("model_hi_flag",   hi_flag,   m.hi);
      chk("model_lo_enter",  lo_enter,  m.le);
      chk("model_hi_enter",  hi_enter,  m.he);
      chk("model_ovf",       ovf,       m.ovf);
      chk("model_unf",       unf,       m.unf);
      chk("model_zero_flag", zero_flag, m.zero);
    end
  end

  task automatic step(input logic e, input logic l, input logic i, input logic d,
                      input logic c, input logic [W-1:0] v);
    enable = e; load = l; inc = i; dec = d; clr_sticky = c; load_val = v;
    @(posedge clk);
    #1;
  endtask

  task automatic noop();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    int r;
    logic [W-1:0] v;
    repeat (3) @(posedge clk);
    #1;
    // Reset values while reset is held
    chk("rst_lo_flag", lo_flag, 1'b1);
    chk("rst_zero", zero_flag, 1'b1);
    chk("rst_hi_flag", hi_flag, 1'b0);
    reset = 1'b0;
    noop();
    chk("release_lo_enter", lo_enter, 1'b0);
    chk("release_lo_flag", lo_flag, 1'b1);
    chk("release_ovf", ovf, 1'b0);

    // Count up 0 -> 12
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      if (k == 6) chk("up_low_at5", lo_flag, 1'b1);
      if (k == 7) chk("up_mid_at6", lo_flag, 1'b0);
    end
    noop();
    chk("up_hi_flag", hi_flag, 1'b1);
    chk("up_hi_enter", hi_enter, 1'b1);
    noop();
    chk("up_hi_enter_single", hi_enter, 1'b0);

    // Count down 12 -> 2
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      if (k == 2 || k == 3) chk("dn_hi_hold", hi_flag, 1'b1);
      if (k == 4) chk("dn_mid_at9", hi_flag | lo_flag, 1'b0);
      if (k == 10) begin
        chk("dn_lo_enter", lo_enter, 1'b1);
        chk("dn_lo_flag", lo_flag, 1'b1);
      end
    end

    // Load 255 then wrap with one increment
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
    noop();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    noop();
    chk("wrap_ovf", ovf, 1'b1);
    chk("wrap_lo_enter", lo_enter, 1'b1);
    chk("wrap_zero", zero_flag, 1'b1);
    chk("wrap_unf", unf, 1'b0);
    chk("wrap_hi_flag", hi_flag, 1'b0);

    // Underflow under a held clear: set wins
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    chk("sticky_set_wins", unf, 1'b1);
    noop();
    chk("sticky_hold", unf, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    chk("sticky_cleared", unf, 1'b0);

    // Reach HIGH with ovf set, then async reset between edges
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd20);
    noop();
    chk("pre_rst_hi", hi_flag, 1'b1);
    chk("pre_rst_ovf", ovf, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("async_lo_flag", lo_flag, 1'b1);
    chk("async_hi_flag", hi_flag, 1'b0);
    chk("async_ovf", ovf, 1'b0);
    chk("async_zero", zero_flag, 1'b1);
    #1 reset = 1'b0;
    noop();
    chk("post_rst_lo_enter", lo_enter, 1'b0);
    chk("post_rst_lo_flag", lo_flag, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0:       v = 8'($urandom_range(0, 3));
        1:       v = 8'($urandom_range(252, 255));
        2:       v = 8'($urandom_range(LO - 2, HI + 2));
        default: v = 8'($urandom);
      endcase
      if (r <= 3)      step($urandom_range(0, 9) != 0, 1'b0, 1'b1, 1'b0, $urandom_range(0, 7) == 0, v);
      else if (r <= 7) step($urandom_range(0, 9) != 0, 1'b0, 1'b0, 1'b1, $urandom_range(0, 7) == 0, v);
      else if (r == 8) step(1'b1, 1'b1, 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, v);
      else             step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
